// File: rtl/pipe_reg_elastic.sv
// Elastic register chain: DEPTH stages, each with its own valid bit, valid/ready at both ends.
// Bubbles collapse toward the output; flush kills all entries but leaves the data registers untouched.
module pipe_reg_elastic #(
  parameter int                   BIT_WIDTH = 32,
  parameter int                   DEPTH     = 2,
  parameter logic [BIT_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BIT_WIDTH-1:0]         in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BIT_WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]     v;
  logic [DEPTH-1:0]     v_nxt;
  logic [DEPTH-1:0]     rdy;
  logic [DEPTH-1:0]     up_v;
  logic [BIT_WIDTH-1:0] d    [DEPTH];
  logic [BIT_WIDTH-1:0] up_d [DEPTH];
  logic [OCC_W-1:0]     occ_nxt;

  // A stage can take a new entry if it is empty or everything downstream of it can move.
  always_comb begin : ready_chain
    logic acc;
    acc = out_ready;
    rdy = '0;
    for (int k = DEPTH-1; k >= 0; k--) begin
      acc    = ~v[k] | acc;
      rdy[k] = acc;
    end
  end

  always_comb begin
    up_v    = '0;
    up_v[0] = in_valid;
    up_d[0] = in_data;
    for (int k = 1; k < DEPTH; k++) begin
      up_v[k] = v[k-1];
      up_d[k] = d[k-1];
    end
  end

  always_comb begin
    v_nxt = v;
    if (flush) begin
      v_nxt = '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (rdy[k]) v_nxt[k] = up_v[k];
      end
    end
  end

  always_comb begin
    occ_nxt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_nxt = occ_nxt + OCC_W'(v_nxt[k]);
    end
  end

  // Data registers only load real entries, so bubbles never toggle them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v         <= '0;
      occupancy <= '0;
      for (int k = 0; k < DEPTH; k++) d[k] <= RESET_VAL;
    end else begin
      v         <= v_nxt;
      occupancy <= occ_nxt;
      for (int k = 0; k < DEPTH; k++) begin
        if (!flush && rdy[k] && up_v[k]) d[k] <= up_d[k];
      end
    end
  end

  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = v[DEPTH-1] & ~flush;
  assign out_data  = d[DEPTH-1];

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Bench for pipe_reg_elastic (DEPTH=3, 8-bit): directed scenarios plus randomized traffic
// checked by a FIFO-queue scoreboard and a push/pop occupancy model.
module tb_pipe_reg_elastic;

  localparam int         W     = 8;
  localparam int         D     = 3;
  localparam logic [7:0] RVAL  = 8'hC3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] sb_q [$];
  int m_occ = 0;

  pipe_reg_elastic #(.BIT_WIDTH(W), .DEPTH(D), .RESET_VAL(RVAL)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs just after the edge; return at the following negedge
  // after recording any accepted item in the scoreboard.
  task automatic step(input logic iv, input logic [W-1:0] id, input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    if (reset && iv && in_ready && !fl) sb_q.push_back(id);
  endtask

  // Monitor: pops and compares on every output handshake, tracks occupancy as pushes - pops.
  initial begin : monitor
    logic exp_ir;
    logic [W-1:0] exp_d;
    forever begin
      @(negedge clk);
      #0;
      if (!reset) begin
        sb_q.delete();
        m_occ = 0;
      end else begin
        exp_ir = !flush && ((m_occ < D) || out_ready);
        chk("occupancy", 32'(occupancy), 32'(m_occ));
        chk("in_ready", 32'(in_ready), 32'(exp_ir));
        if (flush) chk("out_valid_in_flush", 32'(out_valid), 32'd0);
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_empty: got out_data %0h expected no item at %0t", out_data, $time);
          end else begin
            exp_d = sb_q.pop_front();
            chk("out_data", 32'(out_data), 32'(exp_d));
          end
        end
        if (flush) begin
          sb_q.delete();
          m_occ = 0;
        end else begin
          m_occ = m_occ + int'(in_valid && exp_ir) - int'(out_valid && out_ready);
        end
      end
    end
  end

  initial begin : driver
    logic [0:5] ov_exp1;
    // reset values while held
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'(RVAL));
    @(posedge clk);
    #3;
    reset = 1'b1;

    // 1: streaming, out_ready=1; first valid 3 cycles after push of 0x11
    ov_exp1 = 6'b000111;
    for (int i = 0; i < 6; i++) begin
      step(i < 3, (i == 0) ? 8'h11 : (i == 1) ? 8'h22 : 8'h33, 1'b1, 1'b0);
      chk("t1_in_ready", 32'(in_ready), 32'd1);
      chk("t1_out_valid", 32'(out_valid), 32'(ov_exp1[i]));
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t1_drained", 32'(out_valid), 32'd0);

    // 2: fill while stalled, then pass-through ready
    step(1'b1, 8'hA1, 1'b0, 1'b0);
    step(1'b1, 8'hA2, 1'b0, 1'b0);
    step(1'b1, 8'hA3, 1'b0, 1'b0);
    step(1'b1, 8'hA4, 1'b0, 1'b0);
    chk("t2_full_occ", 32'(occupancy), 32'd3);
    chk("t2_full_in_ready", 32'(in_ready), 32'd0);
    chk("t2_full_out_data", 32'(out_data), 32'hA1);
    step(1'b1, 8'hA4, 1'b1, 1'b0);
    chk("t2_passthru_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t2_all_out", 32'(sb_q.size()), 32'd0);

    // 3: bubble collapse under stall
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t3_occ", 32'(occupancy), 32'd2);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t3_first_valid", 32'(out_valid), 32'd1);
    chk("t3_first_data", 32'(out_data), 32'h01);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t3_second_valid", 32'(out_valid), 32'd1);
    chk("t3_second_data", 32'(out_data), 32'h02);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t3_empty", 32'(out_valid), 32'd0);

    // 4: flush with two entries held and in_valid high
    step(1'b1, 8'hB1, 1'b0, 1'b0);
    step(1'b1, 8'hB2, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b1);
    chk("t4_flush_occ_before", 32'(occupancy), 32'd2);
    chk("t4_flush_in_ready", 32'(in_ready), 32'd0);
    chk("t4_flush_out_valid", 32'(out_valid), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t4_after_occ", 32'(occupancy), 32'd0);
    chk("t4_after_in_ready", 32'(in_ready), 32'd1);
    step(1'b1, 8'h55, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t4_latency_not_yet", 32'(out_valid), 32'd0);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t4_55_valid", 32'(out_valid), 32'd1);
    chk("t4_55_data", 32'(out_data), 32'h55);

    // 5: asynchronous reset between edges
    step(1'b1, 8'hC1, 1'b0, 1'b0);
    step(1'b1, 8'hC2, 1'b0, 1'b0);
    step(1'b1, 8'hC4, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t5_pre_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("t5_async_out_valid", 32'(out_valid), 32'd0);
    chk("t5_async_occ", 32'(occupancy), 32'd0);
    chk("t5_async_out_data", 32'(out_data), 32'(RVAL));
    @(posedge clk);
    #3;
    reset = 1'b1;
    step(1'b1, 8'hD1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t5_no_stale", 32'(out_valid), 32'd0);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t5_d1_valid", 32'(out_valid), 32'd1);
    chk("t5_d1_data", 32'(out_data), 32'hD1);

    // 6: random traffic
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t6_queue_empty", 32'(sb_q.size()), 32'd0);
    chk("t6_final_occ", 32'(occupancy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_reg_elastic.md
Name: pipe_reg_elastic

Overview:
- Parametrised successor of the single enabled register: a chain of DEPTH register stages.
- Each stage carries its own valid bit.
- Uses a valid/ready handshake at both ends, with bubble-collapsing stall propagation, synchronous flush and an occupancy count.
- Used between datapath units (e.g. decode→execute, memory return paths) wherever a stall must back-pressure upstream without losing data.

Parameters:
- BIT_WIDTH, 32, data width of every stage.
- DEPTH, 2, number of register stages; legal range 1..16.
- RESET_VAL, 0, value loaded into every data register on reset (BIT_WIDTH wide).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset. Asserted (0) clears all state immediately. Deassertion is synchronised to clk outside this block.
- flush  input  1  synchronous kill of all held entries.
- in_valid  input  1  upstream offers in_data.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  BIT_WIDTH  upstream data.
- out_valid  output  1  stage DEPTH-1 holds a valid entry.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  BIT_WIDTH  data of stage DEPTH-1.
- occupancy  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Stages are indexed 0 (input side) .. DEPTH-1 (output side). v[k] is the valid bit and d[k] the data of stage k.

Reset (reset=0, asynchronous):
- All v[k]=0 and all d[k]=RESET_VAL.
- Hence out_valid=0, occupancy=0, out_data=RESET_VAL.
- in_ready=1 once reset is released and flush=0.
- Reset mid-transfer discards all entries; no partial state survives.

Ready chain (combinational):
- rdy[DEPTH-1] = out_ready | ~v[DEPTH-1].
- rdy[k] = ~v[k] | rdy[k+1].
- in_ready = rdy[0] & ~flush.
- out_valid = v[DEPTH-1] & ~flush.
- out_data = d[DEPTH-1] at all times.

Clock edge, flush=0:
- For each k with rdy[k]=1: v[k] <= upstream valid (in_valid for k=0, else v[k-1]).
- d[k] <= upstream data only when rdy[k] & upstream valid. Otherwise d[k] holds, so no toggling on bubbles.
- Stages with rdy[k]=0 hold both v and d (stall).
- A transfer occurs at the input when in_valid & in_ready, and at the output when out_valid & out_ready.

Bubbles and ordering:
- Bubbles collapse: an empty stage accepts even if downstream is stalled.
- Entries never overtake, duplicate or drop. Output order equals input order.

Latency and throughput:
- On an empty chain, an item accepted at edge t is first presented with out_valid=1 after edge t+DEPTH-1, i.e. DEPTH cycles after in_valid was sampled.
- With out_ready held at 1, throughput is 1 item/cycle.

Full (all v=1):
- out_ready=0 → in_ready=0.
- out_ready=1 → in_ready=1 in the same cycle (pass-through ready). Simultaneous push and pop keeps occupancy at DEPTH.

Flush (flush=1 at an edge):
- All v[k] <= 0. d[k] is retained.
- While flush=1, in_ready=0 and out_valid=0, so no transfer is counted at either end.
- Flush has priority over in_valid and out_ready.
- The cycle after flush deasserts: occupancy=0, in_ready=1.

occupancy:
- Registered popcount of v, updated at the same edge as v.
- Values 0..DEPTH; never exceeds DEPTH.

Path and width notes:
- in_ready has a combinational path from out_ready through DEPTH gates. This is accepted; DEPTH is limited to 16 for this reason.
- DEPTH=1 reduces to a single stage with rdy[0] = out_ready | ~v[0].

Test Plan:
- DEPTH=3, BIT_WIDTH=8, out_ready=1. Push 0x11,0x22,0x33 on consecutive cycles → out_data 0x11,0x22,0x33 on consecutive cycles, first valid 3 cycles after the 0x11 push. occupancy never exceeds 3; in_ready stays 1.
- Fill with 0xA1..0xA3 while out_ready=0 → occupancy=3, in_ready=0, out_data=0xA1 held. Then raise out_ready with in_valid=1, data 0xA4 → same-cycle in_ready=1; outputs 0xA1..0xA4 in order, no loss.
- Bubble collapse: push 0x01, idle 2 cycles, push 0x02, with out_ready=0 → both collapse to stages 2 and 1, occupancy=2. Releasing out_ready gives 0x01 then 0x02 back to back.
- Flush with occupancy=2 and in_valid=1 → in_ready=0 and out_valid=0 during flush, no handshake counted. Next cycle occupancy=0, in_ready=1; the next push 0x55 exits after 3 cycles.
- Assert reset asynchronously mid-stream between edges → out_valid, occupancy and out_data (=RESET_VAL) clear immediately, without waiting for a clock edge. After release, normal operation resumes with no stale data.
- Random in_valid/out_ready at 50% each for 10k cycles against a queue scoreboard → exact in-order match, occupancy = pushes − pops at every cycle.
